// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, FSM states and
// divider / counter-width helpers used by the tx and rx paths.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready word handshake between a producer and the
// UART transmitter.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and pulses bit_end_o on
// the last cycle of each bit; restart_i holds it at zero.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic bit_end_o
);
    localparam int            CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end_o = (cnt_q == LAST);

    // wrap at the bit boundary or when held in restart
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, LSB-first data,
// optional parity, 1 or 2 stop bits, gapless back-to-back.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 27000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_param_if.slave  tx_if,
    output logic            tx,
    output logic            busy
);
    localparam int         DIV       = calc_div(CLK_FREQ, BAUD_RATE);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_param: CLK_FREQ/BAUD_RATE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]           bit_q, bit_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q;
    logic                 bit_end;
    logic                 last_stop;
    logic                 hs;
    logic                 par_in;

    uart_baud_gen #(
        .DIV(DIV)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(state_q == ST_IDLE),
        .bit_end_o(bit_end)
    );

    assign last_stop = (state_q == ST_STOP) && bit_end && (bit_q == LAST_STOP);
    assign tx_if.tx_ready = rst_n && ((state_q == ST_IDLE) || last_stop);
    assign hs = tx_if.tx_valid && tx_if.tx_ready;
    assign par_in = (PARITY == PAR_ODD) ? ~(^tx_if.tx_data) : ^tx_if.tx_data;
    assign tx = tx_q;
    assign busy = busy_q;

    // frame sequencing and next line level
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        par_d   = par_q;
        tx_d    = tx_q;
        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // a handshake (idle or last stop cycle) always starts a frame
        if (hs) begin
            state_d = ST_START;
            tx_d    = 1'b0;
            shreg_d = tx_if.tx_data;
            par_d   = par_in;
            bit_d   = '0;
        end
    end

    // state, datapath and registered line outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. Serialises one data word per valid/ready handshake into a standard asynchronous frame: start bit, LSB-first data, optional parity, 1 or 2 stop bits. It replaces fixed-pattern serial test generators and is the transmit front end for any debug or host link on the board, driven by a 27 MHz system clock.

Parameters:
CLK_FREQ, 27000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s; DIV = CLK_FREQ / BAUD_RATE (integer, truncated), DIV >= 2 required
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
tx_data  in  DATA_BITS  word to transmit, sampled on handshake
tx_valid  in  1  tx_data valid
tx_ready  out  1  transmitter can accept a word this cycle
tx  out  1  serial line output, idle high
busy  out  1  frame in progress (any state other than IDLE)

Behaviour:
- Reset (async assert, sync-style release on clk): tx=1, busy=0, tx_ready=0 while rst_n low; state IDLE, bit and baud counters 0. tx is driven high immediately when rst_n falls, including mid-frame; the frame is abandoned, not resumed.
- tx_ready = 1 in IDLE, and also during the final clk of the last stop bit (gapless back-to-back). 0 otherwise.
- Handshake: tx_valid && tx_ready on a rising edge latches tx_data into a shift register. tx_valid while tx_ready=0 is ignored; tx_data changes during a frame do not affect it.
- Latency: tx goes 0 (start bit) in the cycle immediately following the handshake edge.
- FSM: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE, or STOP -> START directly if handshake occurs on last stop cycle.
- Every bit, including each stop bit, lasts exactly DIV clk cycles. Baud counter counts 0..DIV-1, restarts at 0 on every state entry.
- DATA: DATA_BITS bits, LSB first, shift register shifts right at each bit boundary.
- Parity bit: even = XOR of data bits; odd = inverted XOR. Computed from latched word at handshake.
- STOP: tx=1 for STOP_BITS*DIV cycles.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV cycles; zero idle cycles between frames when tx_valid held.
- tx, busy registered (glitch-free line).
- Illegal parameter values: elaboration-time error, no runtime fallback.

Decomposition:
- Package uart_pkg: parity constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2), FSM state encoding, function computing DIV and counter width via $clog2.
- Sub-module uart_baud_gen: DIV-cycle counter with synchronous restart input and one-cycle bit_end pulse; reused by a later uart_rx_param.

Test Plan:
(Bench uses CLK_FREQ=1000, BAUD_RATE=100 -> DIV=10.)
1. 8N1, send 0xA5 -> tx: 0 for 10 cycles, then 1,0,1,0,0,1,0,1 each 10 cycles, then 1 for 10; busy high for 100 cycles; tx_ready back at cycle 99 after handshake.
2. PARITY=2, send 0x07 -> parity bit 1; PARITY=1, send 0x07 -> parity bit 0; frame 110 cycles.
3. STOP_BITS=2, DATA_BITS=7, send 0x7F -> stop high 20 cycles, frame 100 cycles, 7 data bits all 1.
4. Back-to-back: tx_valid held with 0x55 then 0x0F -> second start bit begins exactly 100 cycles after first; no idle cycle between frames.
5. Reset mid-frame: pull rst_n low during data bit 3 -> tx=1 same cycle before next clk edge, busy=0, tx_ready=0; after release, tx_ready=1 and a 0x3C frame is transmitted correctly.
6. tx_valid pulsed with 0xFF while busy, tx_data changed mid-frame -> ignored; in-flight frame bits unchanged.
